num_class_scan_ctrl: RTL and testbench

//   Sequencer for the 4-bit number classifier: prime p = {2,3,5,7,11,13}; div3 = {0,3,6,9,12,15}.
//   On start, it sweeps a value range [lo..hi], one value per clock, and accumulates

---
 rtl/num_class_scan_ctrl_if.sv | 40 ++++
 rtl/num_class_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_num_class_scan_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/num_class_scan_ctrl_if.sv
// Host <-> scan sequencer bundle for the 4-bit number classifier.
// CLASS_STREAM_EN adds the per-value classification stream signals.
interface num_class_scan_ctrl_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic [3:0]       lo;
    logic [3:0]       hi;
    logic             busy;
    logic             done;
    logic             err;
    logic [3:0]       cur_val;
    logic [CNT_W-1:0] prime_cnt;
    logic [CNT_W-1:0] div3_cnt;
`ifdef CLASS_STREAM_EN
    logic             out_valid;
    logic             out_p;
    logic             out_div;

    modport master (
        output start, lo, hi,
        input  busy, done, err, cur_val, prime_cnt, div3_cnt,
        input  out_valid, out_p, out_div
    );
    modport slave (
        input  start, lo, hi,
        output busy, done, err, cur_val, prime_cnt, div3_cnt,
        output out_valid, out_p, out_div
    );
`else
    modport master (
        output start, lo, hi,
        input  busy, done, err, cur_val, prime_cnt, div3_cnt
    );
    modport slave (
        input  start, lo, hi,
        output busy, done, err, cur_val, prime_cnt, div3_cnt
    );
`endif
endinterface

// File: rtl/num_class_scan_ctrl.sv
// Range sweeper for the 4-bit classifier: counts primes and multiples of 3 in [lo..hi].
// Optional feature macro: CLASS_STREAM_EN (exposes the per-value classification stream).
module num_class_scan_ctrl #(
    parameter int CNT_W = 5
) (
    input logic                  clk,
    input logic                  rst,
    num_class_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       hi_q, hi_d;
    logic [3:0]       cur_q, cur_d;
    logic [CNT_W-1:0] prime_q, prime_d;
    logic [CNT_W-1:0] div3_q, div3_d;
    logic             err_q, err_d;
    logic             done_q;
    logic             cls_p;
    logic             cls_div;

    function automatic logic is_prime(input logic [3:0] v);
        case (v)
            4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: is_prime = 1'b1;
            default:                              is_prime = 1'b0;
        endcase
    endfunction

    function automatic logic is_div3(input logic [3:0] v);
        case (v)
            4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15: is_div3 = 1'b1;
            default:                              is_div3 = 1'b0;
        endcase
    endfunction

    assign cls_p   = is_prime(cur_q);
    assign cls_div = is_div3(cur_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= 4'd0;
            cur_q   <= 4'd0;
            prime_q <= '0;
            div3_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            cur_q   <= cur_d;
            prime_q <= prime_d;
            div3_q  <= div3_d;
            err_q   <= err_d;
            // done is registered off the DONE state, so it trails DONE by one cycle
            done_q  <= (state_q == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        cur_d   = cur_q;
        prime_d = prime_q;
        div3_d  = div3_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    prime_d = '0;
                    div3_d  = '0;
                    if (bus.lo <= bus.hi) begin
                        hi_d    = bus.hi;
                        cur_d   = bus.lo;
                        err_d   = 1'b0;
                        state_d = SCAN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                prime_d = prime_q + {{(CNT_W-1){1'b0}}, cls_p};
                div3_d  = div3_q + {{(CNT_W-1){1'b0}}, cls_div};
                // Equality stop keeps hi=15 from wrapping cur_val back to 0
                if (cur_q == hi_q) begin
                    state_d = DONE;
                end else begin
                    cur_d = cur_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q == SCAN) || (state_q == DONE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.cur_val   = cur_q;
    assign bus.prime_cnt = prime_q;
    assign bus.div3_cnt  = div3_q;

`ifdef CLASS_STREAM_EN
    assign bus.out_valid = (state_q == SCAN);
    assign bus.out_p     = cls_p;
    assign bus.out_div   = cls_div;
`endif

endmodule

// File: tb/tb_num_class_scan_ctrl.sv
// Self-checking bench for num_class_scan_ctrl: vector table plus scoreboard queue,
// with hand sequences for ignored start, mid-scan reset and the optional stream.
module tb_num_class_scan_ctrl;

    localparam int CNT_W = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    num_class_scan_ctrl_if #(.CNT_W(CNT_W)) bus ();

    num_class_scan_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [3:0] lo;
        logic [3:0] hi;
        int         p;
        int         d;
        int         err;
        int         lat;
    } vec_t;

    typedef struct {
        int p;
        int d;
        int err;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

`ifdef CLASS_STREAM_EN
    logic [5:0] strm[$];
    always @(negedge clk) begin
        if (bus.out_valid) strm.push_back({bus.cur_val, bus.out_p, bus.out_div});
    end
`endif

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] lo, input logic [3:0] hi,
                          input int p, input int d, input int err, input bit push);
        exp_t e;
        e.p = p; e.d = d; e.err = err;
        if (push) sbq.push_back(e);
        bus.lo    = lo;
        bus.hi    = hi;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic await_done(input string name, input int lat, input int cyc0);
        int   cyc;
        bit   seen;
        exp_t e;
        cyc  = cyc0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            tick();
            cyc++;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            chk({name, "_timeout"}, 0, 1);
            return;
        end
        chk({name, "_latency"}, cyc, lat);
        if (sbq.size() == 0) begin
            chk({name, "_unexpected_done"}, 1, 0);
            return;
        end
        e = sbq.pop_front();
        chk({name, "_prime"}, int'(bus.prime_cnt), e.p);
        chk({name, "_div3"},  int'(bus.div3_cnt),  e.d);
        chk({name, "_err"},   int'(bus.err),       e.err);
        tick();
        chk({name, "_done_pulse"}, int'(bus.done), 0);
        chk({name, "_busy_idle"},  int'(bus.busy), 0);
        tick();
        chk({name, "_prime_hold"}, int'(bus.prime_cnt), e.p);
        chk({name, "_err_hold"},   int'(bus.err),       e.err);
    endtask

    task automatic count_dones(input string name, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.done) cnt++;
        end
        chk(name, cnt, 0);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{lo: 4'd0,  hi: 4'd15, p: 6, d: 6, err: 0, lat: 17};
        vecs[1]  = '{lo: 4'd3,  hi: 4'd3,  p: 1, d: 1, err: 0, lat: 2};
        vecs[2]  = '{lo: 4'd4,  hi: 4'd4,  p: 0, d: 0, err: 0, lat: 2};
        vecs[3]  = '{lo: 4'd9,  hi: 4'd2,  p: 0, d: 0, err: 1, lat: 1};
        vecs[4]  = '{lo: 4'd11, hi: 4'd15, p: 2, d: 2, err: 0, lat: 6};
        vecs[5]  = '{lo: 4'd0,  hi: 4'd7,  p: 4, d: 3, err: 0, lat: 9};
        vecs[6]  = '{lo: 4'd15, hi: 4'd15, p: 0, d: 1, err: 0, lat: 2};
        vecs[7]  = '{lo: 4'd8,  hi: 4'd7,  p: 0, d: 0, err: 1, lat: 1};
        vecs[8]  = '{lo: 4'd14, hi: 4'd15, p: 0, d: 1, err: 0, lat: 3};
        vecs[9]  = '{lo: 4'd0,  hi: 4'd0,  p: 0, d: 1, err: 0, lat: 2};
        vecs[10] = '{lo: 4'd1,  hi: 4'd2,  p: 1, d: 0, err: 0, lat: 3};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.lo    = 4'd0;
        bus.hi    = 4'd0;
        tick();
        tick();
        chk("rst_busy",  int'(bus.busy),      0);
        chk("rst_done",  int'(bus.done),      0);
        chk("rst_err",   int'(bus.err),       0);
        chk("rst_cur",   int'(bus.cur_val),   0);
        chk("rst_prime", int'(bus.prime_cnt), 0);
        chk("rst_div3",  int'(bus.div3_cnt),  0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            launch(vecs[i].lo, vecs[i].hi, vecs[i].p, vecs[i].d, vecs[i].err, 1'b1);
            chk($sformatf("v%0d_busy", i), int'(bus.busy), 1);
            await_done($sformatf("v%0d", i), vecs[i].lat, 0);
        end

        // start during SCAN with a different range must be ignored
        launch(4'd0, 4'd7, 4, 3, 0, 1'b1);
        tick();
        tick();
        bus.lo    = 4'd8;
        bus.hi    = 4'd15;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        await_done("ignore_start", 9, 3);
        count_dones("ignore_start_no_extra", 20);

        // reset during the fourth SCAN cycle
        launch(4'd0, 4'd15, 0, 0, 0, 1'b0);
        tick();
        tick();
        tick();
        chk("mid_cur_before_rst", int'(bus.cur_val), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy",  int'(bus.busy),      0);
        chk("mid_rst_done",  int'(bus.done),      0);
        chk("mid_rst_err",   int'(bus.err),       0);
        chk("mid_rst_cur",   int'(bus.cur_val),   0);
        chk("mid_rst_prime", int'(bus.prime_cnt), 0);
        chk("mid_rst_div3",  int'(bus.div3_cnt),  0);
        count_dones("mid_rst_no_done", 20);
        launch(4'd11, 4'd15, 2, 2, 0, 1'b1);
        await_done("after_rst", 6, 0);

`ifdef CLASS_STREAM_EN
        strm.delete();
        launch(4'd5, 4'd7, 2, 1, 0, 1'b1);
        await_done("stream", 4, 0);
        chk("stream_len", strm.size(), 3);
        if (strm.size() == 3) begin
            chk("stream_0", int'(strm[0]), int'({4'd5, 1'b1, 1'b0}));
            chk("stream_1", int'(strm[1]), int'({4'd6, 1'b0, 1'b1}));
            chk("stream_2", int'(strm[2]), int'({4'd7, 1'b1, 1'b0}));
        end
`endif

        chk("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
